serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor. It computes diff = a - b (mod 2^WIDTH) and a final borrow, one bit per clock, LSB first. Each bit step uses a single full-subtractor cell and one borrow flip-flop. It is the subtract-direction counterpart to the adder cells in the arithmetic library, and is intended for area-constrained datapaths that can tolerate a latency of WIDTH cycles.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells.
package arith_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bo is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bin;
  assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b mod 2^WIDTH, LSB first, one bit per clock.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  sub_state_e       state_q;
  sub_state_e       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             bo_bit;
  logic             last;

  full_subtractor u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (brw),
    .d   (d_bit),
    .bo  (bo_bit)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, registered flags and serial datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          brw    <= bo_bit;
          if (last) begin
            // Working register keeps diff stable during RUN; publish only here.
            diff <= {d_bit, res_sh[WIDTH-1:1]};
            bout <= bo_bit;
            cnt  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got diff=%h bout=%b at cycle %0d, required no done", diff, bout, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (diff !== e.diff || bout !== e.bout || cyc != e.cyc) begin
          fails++;
          $display("FAIL result: got diff=%h bout=%b cycle=%0d, required diff=%h bout=%b cycle=%0d",
                   diff, bout, cyc, e.diff, e.bout, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Issue one op with a single-cycle start; returns the accepting cycle.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, output int acc);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.diff = ed;
    e.bout = eb;
    e.cyc  = acc + int'(W);
    sb.push_back(e);
    check("busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int   acc;
    logic idle_ok;
    exp_t e;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_busy_low", 32'(idle_ok), 32'd1);

    // Basic op, then outputs held
    issue(8'h5A, 8'h23, 8'h37, 1'b0, acc);
    wait_empty();
    repeat (4) @(negedge clk);
    check("hold_diff", 32'(diff), 32'h37);
    check("hold_bout", 32'(bout), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);

    // Borrow cases
    issue(8'h10, 8'h20, 8'hF0, 1'b1, acc);
    wait_empty();
    issue(8'h00, 8'h01, 8'hFF, 1'b1, acc);
    wait_empty();
    issue(8'hFF, 8'hFF, 8'h00, 1'b0, acc);
    wait_empty();

    // Start during RUN is ignored; operand changes mid-RUN have no effect
    issue(8'h5A, 8'h23, 8'h37, 1'b0, acc);
    repeat (2) @(negedge clk);
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'hC3;
    b = 8'hE7;
    @(negedge clk);
    check("diff_stable_in_run", 32'(diff), 32'h00);
    wait_empty();
    repeat (12) @(negedge clk);
    check("busy_after_reject", 32'(busy), 32'd0);

    // Back-to-back with start held high: second accept 10 cycles later
    @(negedge clk);
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    e.diff = 8'hF0; e.bout = 1'b1; e.cyc = acc + 8;
    sb.push_back(e);
    e.diff = 8'hFF; e.bout = 1'b1; e.cyc = acc + 18;
    sb.push_back(e);
    @(negedge clk);
    a = 8'h00;
    b = 8'h01;
    repeat (10) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_second_op", 32'(busy), 32'd1);
    wait_empty();
    repeat (4) @(negedge clk);

    // Reset at counter=4 aborts the op
    @(negedge clk);
    a = 8'h33;
    b = 8'h11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(diff), 32'd0);

    issue(8'h80, 8'h01, 8'h7F, 1'b0, acc);
    wait_empty();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
